// File: rtl/klp32_chk_pkg.sv
// rtl/klp32_chk_pkg.sv - shared types and constants for the KLP32 commit checker
package klp32_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } chk_state_e;

   localparam int DEFAULT_XLEN = 32;

   // Channel slots as packed into exp_data/act_data
   localparam int CH_PC  = 0;
   localparam int CH_ALU = 1;
   localparam int CH_WB  = 2;
   localparam int CH_MEM = 3;

endpackage

// File: rtl/klp32_sync_fifo.sv
// rtl/klp32_sync_fifo.sv - single-clock FIFO with occupancy level, push refused when full
module klp32_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wrData,
   output logic [WIDTH-1:0]         rdData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign full   = (level == DEPTH[AW:0]);
   assign empty  = (level == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign rdData = mem[rdPtr];

   // Storage needs no reset; level alone decides what is valid
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wrData;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         if (doPush && !doPop)      level <= level + 1'b1;
         else if (doPop && !doPush) level <= level - 1'b1;
      end
   end

endmodule

// File: rtl/klp32_commit_checker.sv
// rtl/klp32_commit_checker.sv - commit-trace checker: expected-vector FIFO, masked compare,
// saturating test/pass/fail counters and first-failure capture
module klp32_commit_checker
   import klp32_chk_pkg::*;
#(
   parameter int XLEN         = DEFAULT_XLEN,
   parameter int NUM_CH       = 4,
   parameter int DEPTH        = 16,
   parameter int CNT_W        = 16,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     finish,
   input  logic                     exp_valid,
   output logic                     exp_ready,
   input  logic [NUM_CH*XLEN-1:0]   exp_data,
   input  logic [NUM_CH-1:0]        exp_mask,
   input  logic                     act_valid,
   input  logic [NUM_CH*XLEN-1:0]   act_data,
   output logic [CNT_W-1:0]         num_tests,
   output logic [CNT_W-1:0]         num_passes,
   output logic [CNT_W-1:0]         num_fails,
   output logic [CNT_W-1:0]         first_fail_idx,
   output logic [NUM_CH-1:0]        first_fail_ch,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   localparam int DW = NUM_CH * XLEN;
   localparam int EW = DW + NUM_CH;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_e        state;
   logic              finishPend;
   logic [EW-1:0]     headWord;
   logic [DW-1:0]     headData;
   logic [NUM_CH-1:0] headMask;
   logic [NUM_CH-1:0] mismatch;
   logic [NUM_CH-1:0] failVec;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              checkNow;
   logic              doPop;
   logic              underflow;
   logic              failNow;
   logic              wantFinish;

   klp32_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (reset),
      .push   (exp_valid),
      .pop    (doPop),
      .wrData ({exp_mask, exp_data}),
      .rdData (headWord),
      .full   (fifoFull),
      .empty  (fifoEmpty),
      .level  (fifo_level)
   );

   assign {headMask, headData} = headWord;

   always_comb begin
      mismatch = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mismatch[i] = headMask[i] && (headData[i*XLEN +: XLEN] != act_data[i*XLEN +: XLEN]);
      end
   end

   // start pre-empts any commit presented in the same cycle
   assign checkNow   = (state == RUN) && act_valid && !start;
   assign doPop      = checkNow && !fifoEmpty;
   assign underflow  = checkNow && fifoEmpty;
   assign failNow    = underflow || (doPop && (mismatch != '0));
   assign failVec    = underflow ? '1 : mismatch;
   assign wantFinish = finishPend || finish;

   assign exp_ready = !fifoFull;
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign error     = (state == ERROR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         finishPend     <= 1'b0;
         num_tests      <= '0;
         num_passes     <= '0;
         num_fails      <= '0;
         first_fail_idx <= '0;
         first_fail_ch  <= '0;
      end else if (start) begin
         state          <= RUN;
         finishPend     <= finish;
         num_tests      <= '0;
         num_passes     <= '0;
         num_fails      <= '0;
         first_fail_idx <= '0;
         first_fail_ch  <= '0;
      end else begin
         if (checkNow) begin
            if (num_tests != CNT_MAX) num_tests <= num_tests + 1'b1;
            if (failNow) begin
               if (num_fails != CNT_MAX) num_fails <= num_fails + 1'b1;
               // num_fails never returns to zero within a run, so zero marks "no failure yet"
               if (num_fails == '0) begin
                  first_fail_idx <= num_tests;
                  first_fail_ch  <= failVec;
               end
            end else if (num_passes != CNT_MAX) begin
               num_passes <= num_passes + 1'b1;
            end
         end

         if (underflow || (failNow && (STOP_ON_FAIL != 0))) begin
            state      <= ERROR;
            finishPend <= wantFinish;
         end else if ((state == RUN) && wantFinish && fifoEmpty) begin
            state      <= DONE;
            finishPend <= 1'b0;
         end else begin
            finishPend <= wantFinish;
         end
      end
   end

endmodule

// File: tb/tb_klp32_commit_checker.sv
// tb/tb_klp32_commit_checker.sv - randomized and directed bench for klp32_commit_checker
// against a queue-based reference model
module tb_klp32_commit_checker;

   localparam int XLEN    = 32;
   localparam int NUM_CH  = 4;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 4;
   localparam int STOP    = 1;
   localparam int DW      = NUM_CH * XLEN;
   localparam int LW      = $clog2(DEPTH) + 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                finish;
   logic                exp_valid;
   logic                exp_ready;
   logic [DW-1:0]       exp_data;
   logic [NUM_CH-1:0]   exp_mask;
   logic                act_valid;
   logic [DW-1:0]       act_data;
   logic [CNT_W-1:0]    num_tests;
   logic [CNT_W-1:0]    num_passes;
   logic [CNT_W-1:0]    num_fails;
   logic [CNT_W-1:0]    first_fail_idx;
   logic [NUM_CH-1:0]   first_fail_ch;
   logic [LW-1:0]       fifo_level;
   logic                busy;
   logic                done;
   logic                error;

   klp32_commit_checker #(
      .XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .STOP_ON_FAIL(STOP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_mask(exp_mask),
      .act_valid(act_valid), .act_data(act_data),
      .num_tests(num_tests), .num_passes(num_passes), .num_fails(num_fails),
      .first_fail_idx(first_fail_idx), .first_fail_ch(first_fail_ch),
      .fifo_level(fifo_level), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0]     data;
      logic [NUM_CH-1:0] mask;
   } entry_t;

   // Reference model: 0 idle, 1 run, 2 done, 3 error
   entry_t            q[$];
   int                mState;
   int                mTests, mPasses, mFails, mIdx;
   logic [NUM_CH-1:0] mCh;
   bit                mPend;

   int checks = 0;
   int errors = 0;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int satInc(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   function automatic logic [DW-1:0] mkData(input logic [31:0] c0, c1, c2, c3);
      return {c3, c2, c1, c0};
   endfunction

   function automatic logic [DW-1:0] rndData();
      logic [DW-1:0] d;
      for (int c = 0; c < NUM_CH; c++) d[c*XLEN +: XLEN] = $urandom_range(0, 3);
      return d;
   endfunction

   task automatic modelClear();
      mState = 0; mTests = 0; mPasses = 0; mFails = 0; mIdx = 0; mCh = '0; mPend = 0;
   endtask

   task automatic modelFail(input logic [NUM_CH-1:0] vec);
      if (mFails == 0) begin
         mIdx = mTests;
         mCh  = vec;
      end
      mTests = satInc(mTests);
      mFails = satInc(mFails);
   endtask

   task automatic checkAll(input string tag);
      checkVal({tag, ".tests"},  num_tests,      mTests);
      checkVal({tag, ".passes"}, num_passes,     mPasses);
      checkVal({tag, ".fails"},  num_fails,      mFails);
      checkVal({tag, ".ffidx"},  first_fail_idx, mIdx);
      checkVal({tag, ".ffch"},   first_fail_ch,  mCh);
      checkVal({tag, ".level"},  fifo_level,     q.size());
      checkVal({tag, ".ready"},  exp_ready,      q.size() < DEPTH);
      checkVal({tag, ".busy"},   busy,           mState == 1);
      checkVal({tag, ".done"},   done,           mState == 2);
      checkVal({tag, ".error"},  error,          mState == 3);
   endtask

   task automatic step(input string tag, input bit s, input bit f, input bit ev,
                       input logic [DW-1:0] ed, input logic [NUM_CH-1:0] em,
                       input bit av, input logic [DW-1:0] ad);
      int                pre;
      entry_t            e;
      logic [NUM_CH-1:0] mm;
      start = s; finish = f; exp_valid = ev; exp_data = ed; exp_mask = em;
      act_valid = av; act_data = ad;
      pre = q.size();
      if (s) begin
         modelClear();
         mState = 1;
         mPend  = f;
      end else begin
         if (f) mPend = 1;
         if (mState == 1 && av) begin
            if (pre == 0) begin
               modelFail('1);
               mState = 3;
            end else begin
               e  = q.pop_front();
               mm = '0;
               for (int c = 0; c < NUM_CH; c++)
                  if (e.mask[c] && (e.data[c*XLEN +: XLEN] != ad[c*XLEN +: XLEN])) mm[c] = 1'b1;
               if (mm != '0) begin
                  modelFail(mm);
                  if (STOP != 0) mState = 3;
               end else begin
                  mTests  = satInc(mTests);
                  mPasses = satInc(mPasses);
               end
            end
         end else if (mState == 1 && mPend && pre == 0) begin
            mState = 2;
            mPend  = 0;
         end
      end
      if (ev && pre < DEPTH) begin
         e.data = ed;
         e.mask = em;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 0; finish = 0; exp_valid = 0; act_valid = 0;
      checkAll(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, '0, '0, 0, '0);
   endtask

   task automatic push(input string tag, input logic [DW-1:0] d, input logic [NUM_CH-1:0] m);
      step(tag, 0, 0, 1, d, m, 0, '0);
   endtask

   task automatic act(input string tag, input logic [DW-1:0] d);
      step(tag, 0, 0, 0, '0, '0, 1, d);
   endtask

   task automatic startRun(input string tag);
      step(tag, 1, 0, 0, '0, '0, 0, '0);
   endtask

   // Reset is raised between clock edges so its asynchronous effect is visible before the next edge
   task automatic doReset(input string tag);
      start = 0; finish = 0; exp_valid = 0; act_valid = 0;
      #2 reset = 1'b1;
      #1;
      q.delete();
      modelClear();
      checkAll({tag, ".async"});
      @(posedge clk);
      #1 reset = 1'b0;
      checkAll({tag, ".post"});
   endtask

   initial begin
      logic [DW-1:0] d;
      int            guard;
      reset = 1'b1; start = 0; finish = 0; exp_valid = 0; act_valid = 0;
      exp_data = '0; exp_mask = '0; act_data = '0;
      modelClear();
      @(posedge clk);
      #1;
      checkAll("reset");
      reset = 1'b0;
      idle("idle0");

      // Three matching commits
      for (int i = 0; i < 3; i++) push("t1.push", mkData($urandom, $urandom, $urandom, $urandom), 4'b1111);
      startRun("t1.start");
      for (int i = 0; i < 3; i++) act("t1.act", q[0].data);
      checkVal("t1.tests_3", num_tests, 3);
      checkVal("t1.passes_3", num_passes, 3);
      checkVal("t1.level_0", fifo_level, 0);

      // Masked mismatch on ALU channel
      startRun("t2.start");
      push("t2.push", mkData(0, 32'h5, 0, 0), 4'b0010);
      act("t2.act", mkData(0, 32'h6, 0, 0));
      checkVal("t2.fails_1", num_fails, 1);
      checkVal("t2.ffch", first_fail_ch, 4'b0010);
      checkVal("t2.ffidx", first_fail_idx, 0);
      checkVal("t2.error", error, 1);

      // Same mismatch masked out
      startRun("t3.start");
      push("t3.push", mkData(0, 32'h5, 0, 0), 4'b1101);
      act("t3.act", mkData(0, 32'h6, 0, 0));
      checkVal("t3.passes_1", num_passes, 1);
      checkVal("t3.fails_0", num_fails, 0);

      // Underflow
      startRun("t4.start");
      act("t4.act", rndData());
      checkVal("t4.ffch_all", first_fail_ch, 4'b1111);
      checkVal("t4.error", error, 1);

      // Fill to full, refused push, push+pop at full, finish and drain
      startRun("t5.start");
      for (int i = 0; i < DEPTH + 1; i++) push("t5.fill", rndData(), $urandom_range(0, 15));
      checkVal("t5.full_ready", exp_ready, 0);
      checkVal("t5.full_level", fifo_level, DEPTH);
      step("t5.pushpop", 0, 0, 1, rndData(), 4'hF, 1, q[0].data);
      checkVal("t5.level_15", fifo_level, DEPTH - 1);
      step("t5.finish", 0, 1, 0, '0, '0, 0, '0);
      guard = 0;
      while (q.size() > 0 && guard < 2 * DEPTH) begin
         act("t5.drain", q[0].data);
         guard++;
      end
      idle("t5.tail");
      checkVal("t5.done", done, 1);

      // Reset in the middle of a run with data buffered
      startRun("t6.start");
      for (int i = 0; i < 7; i++) push("t6.push", rndData(), 4'hF);
      act("t6.act", q[0].data);
      act("t6.act", q[0].data);
      checkVal("t6.level_5", fifo_level, 5);
      doReset("t6.reset");
      checkVal("t6.ready", exp_ready, 1);

      // Counter saturation
      startRun("t7.start");
      push("t7.push", rndData(), 4'hF);
      for (int i = 0; i < CNT_MAX + 4; i++) step("t7.sat", 0, 0, 1, rndData(), 4'hF, 1, q[0].data);
      checkVal("t7.tests_sat", num_tests, CNT_MAX);
      checkVal("t7.passes_sat", num_passes, CNT_MAX);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            doReset("rnd.reset");
         end else begin
            d = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].data : rndData();
            step("rnd", $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0, rndData(), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 0, d);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
